serial_magnitude_comparator: RTL and testbench
==============================================

// Module: serial_magnitude_comparator
// PURPOSE
//  Compares two WIDTH-bit operands a digit at a time (DIGIT bits per clock), most significant digit first.
//  Operands are captured on a start/done handshake, not sampled freely.
//  Produces one-hot registered less_than/equal_to/greater_than and a done pulse.
//  Supports unsigned or two's-complement ordering.
//  Generalised successor of the fixed 4-bit serialized comparator; it is the area-lean comparator for datapath control.
// PARAMETERS
//  WIDTH   16  operand width in bits; must be >= 1 and divisible by DIGIT (otherwise elaboration error)
//  DIGIT   1   bits compared per clock; NDIG = WIDTH/DIGIT digits per operation
//  SIGNED  0   0 = unsigned compare, 1 = two's-complement compare
// PORTS
//  clk           in   1      rising-edge clock
//  reset         in   1      asynchronous, active-high reset
//  start         in   1      request; sampled only when busy=0
//  a_in          in   WIDTH  operand A; captured in the start-accept cycle
//  b_in          in   WIDTH  operand B; captured in the start-accept cycle
//  busy          out  1      high while state=SHIFT
//  done          out  1      single-cycle pulse; results valid from this cycle onward
//  less_than     out  1      A < B
//  equal_to      out  1      A == B
//  greater_than  out  1      A > B
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, shift registers and digit counter 0.
//  Reset is asynchronous and valid in any state.
//  Reset mid-operation aborts the comparison and produces no done pulse.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE  -start->  SHIFT.
//   SHIFT -last digit, or early exit->  DONE.
//   DONE  -start->  SHIFT.
//   DONE  -no start->  IDLE.
//  Start accept (edge T, busy=0):
//   - latch a_in/b_in into shift regs; clear all three result bits; count = 0.
//   - SIGNED=1: invert the operand MSBs at latch, mapping two's-complement order onto unsigned order.
//  Each SHIFT cycle:
//   - compare the top DIGIT bits of both shift regs, shift both left by DIGIT, count++.
//   - First unequal digit sets lt or gt (sticky); later digits are ignored.
//  Result and done:
//   - On leaving SHIFT with no difference found, set equal_to.
//   - done = 1 exactly in the DONE-state cycle.
//   - Result bits hold until the next start accept.
//   - Exactly one result bit is high after done.
//  start while busy=1: ignored, no side effects. start held high in DONE: back-to-back op, no idle gap.
//  Latency (start at edge T): done at cycle T+NDIG+1 (see CONFIGURATION for early exit).
//  Counter width: $clog2(NDIG+1). NDIG=1 is legal (one SHIFT cycle).
// CONFIGURATION
//  Macro EARLY_EXIT_EN:
//   Defined: SHIFT leaves to DONE in the cycle the first differing digit k is seen (k=0 is the MS digit).
//    done at T+k+2; equal operands still take T+NDIG+1.
//   Undefined: fixed latency T+NDIG+1 for all operands (deterministic timing); same results.
// STRUCTURE
//  Package serial_cmp_pkg:
//   - state enum {IDLE, SHIFT, DONE}
//   - result encoding constants CMP_LT=3'b100, CMP_EQ=3'b010, CMP_GT=3'b001
//  Sub-module digit_compare #(DIGIT):
//   - combinational; inputs x, y [DIGIT-1:0]; outputs lt, eq, gt.
//   - instantiated once on the top digit of the shift regs.
// TESTING
//  1. W=4,D=1,S=0, no EARLY_EXIT_EN: a=4'hA, b=4'hB -> less_than=1, done at T+5, busy high 4 cycles.
//  2. W=4,D=1,S=0, EARLY_EXIT_EN: a=4'h8, b=4'h7 -> greater_than=1, done at T+2; a=b=4'h5 -> equal_to=1, done at T+5.
//  3. W=4,D=1,S=1: a=4'h8 (-8), b=4'h7 (+7) -> less_than=1; a=4'hF (-1), b=4'hE (-2) -> greater_than=1.
//  4. W=16,D=4,S=0: a=16'h1234, b=16'h1234 -> equal_to=1, done at T+5.
//     Then start held high -> next op accepted in the DONE cycle.
//  5. Start pulsed while busy with new operands -> ignored; first result unchanged.
//     Reset asserted mid-SHIFT -> all outputs 0 immediately, no done pulse.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// ============================================================================
//  Module      : serial_cmp_pkg
//  Description : Shared types and result encodings for the serial magnitude
//                comparator (FSM state enum, one-hot result constants).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_cmp_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One-hot result encoding, ordered {lt, eq, gt}
    localparam logic [2:0] CMP_LT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_GT = 3'b001;

endpackage : serial_cmp_pkg

`default_nettype wire

// File: rtl/digit_compare.sv
// ============================================================================
//  Module      : digit_compare
//  Description : Combinational unsigned compare of one DIGIT-bit digit pair.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_compare
    import serial_cmp_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    assign lt = (x <  y);
    assign eq = (x == y);
    assign gt = (x >  y);

endmodule : digit_compare

`default_nettype wire

// File: rtl/serial_magnitude_comparator.sv
// ============================================================================
//  Module      : serial_magnitude_comparator
//  Description : Compares two WIDTH-bit operands DIGIT bits per clock, MS digit
//                first, with a start/done handshake and one-hot registered
//                less_than / equal_to / greater_than results. SIGNED=1 selects
//                two's-complement ordering.
//                Optional macro EARLY_EXIT_EN: finish as soon as the first
//                differing digit is seen (otherwise fixed NDIG-cycle compare).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_magnitude_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGIT  = 1,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             less_than,
    output logic             equal_to,
    output logic             greater_than
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG + 1);

    localparam logic [CW-1:0]    c_last_digit = CW'(NDIG - 1);
    // Flipping the sign bit maps two's-complement order onto unsigned order
    localparam logic [WIDTH-1:0] c_msb_flip   =
        (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    generate
        if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_magnitude_comparator: WIDTH must be >= 1 and divisible by DIGIT");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_count;
    logic [2:0]       r_result;

    logic       w_lt;
    logic       w_eq;
    logic       w_gt;
    logic       w_accept;
    logic       w_last;
    logic       w_exit;
    logic [2:0] w_digit_res;
    logic [2:0] w_next_res;

    digit_compare #(
        .DIGIT (DIGIT)
    ) u_digit_compare (
        .x  (r_a[WIDTH-1 -: DIGIT]),
        .y  (r_b[WIDTH-1 -: DIGIT]),
        .lt (w_lt),
        .eq (w_eq),
        .gt (w_gt)
    );

    assign w_accept    = start && (r_state != SHIFT);
    assign w_last      = (r_count == c_last_digit);
    assign w_digit_res = w_eq ? 3'b000 : (w_lt ? CMP_LT : (w_gt ? CMP_GT : 3'b000));
    // First differing digit decides; once a result is latched it is sticky
    assign w_next_res  = (r_result != 3'b000) ? r_result : w_digit_res;

`ifdef EARLY_EXIT_EN
    assign w_exit = w_last || (w_next_res != 3'b000);
`else
    assign w_exit = w_last;
`endif

    // Controller: operand capture, digit-serial shift/compare, result latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_count  <= '0;
            r_result <= 3'b000;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_state  <= SHIFT;
                        r_a      <= a_in ^ c_msb_flip;
                        r_b      <= b_in ^ c_msb_flip;
                        r_count  <= '0;
                        r_result <= 3'b000;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                SHIFT: begin
                    r_a     <= r_a << DIGIT;
                    r_b     <= r_b << DIGIT;
                    r_count <= r_count + CW'(1);
                    if (w_exit) begin
                        r_state  <= DONE;
                        r_result <= (w_next_res == 3'b000) ? CMP_EQ : w_next_res;
                    end else begin
                        r_result <= w_next_res;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy         = (r_state == SHIFT);
    assign done         = (r_state == DONE);
    assign less_than    = r_result[2];
    assign equal_to     = r_result[1];
    assign greater_than = r_result[0];

endmodule : serial_magnitude_comparator

`default_nettype wire

// File: tb/tb_serial_magnitude_comparator.sv
// ============================================================================
//  Module      : tb_serial_magnitude_comparator
//  Description : Directed self-checking bench for serial_magnitude_comparator
//                (unsigned 4-bit, signed 4-bit and 16-bit/4-bit-digit builds).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_magnitude_comparator;

    logic        clk;
    logic        reset;
    logic        s0, s1, s2;
    logic [3:0]  a0, b0, a1, b1;
    logic [15:0] a2, b2;
    wire  [4:0]  st0, st1, st2;   // {busy, done, lt, eq, gt}

    int checks = 0;
    int errors = 0;
    int lat;
    int nbusy;
    int ndone;

`ifdef EARLY_EXIT_EN
    localparam int EARLY = 1;
`else
    localparam int EARLY = 0;
`endif

    serial_magnitude_comparator #(.WIDTH(4), .DIGIT(1), .SIGNED(0)) u_u4 (
        .clk(clk), .reset(reset), .start(s0), .a_in(a0), .b_in(b0),
        .busy(st0[4]), .done(st0[3]), .less_than(st0[2]), .equal_to(st0[1]),
        .greater_than(st0[0])
    );

    serial_magnitude_comparator #(.WIDTH(4), .DIGIT(1), .SIGNED(1)) u_s4 (
        .clk(clk), .reset(reset), .start(s1), .a_in(a1), .b_in(b1),
        .busy(st1[4]), .done(st1[3]), .less_than(st1[2]), .equal_to(st1[1]),
        .greater_than(st1[0])
    );

    serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .SIGNED(0)) u_u16 (
        .clk(clk), .reset(reset), .start(s2), .a_in(a2), .b_in(b2),
        .busy(st2[4]), .done(st2[3]), .less_than(st2[2]), .equal_to(st2[1]),
        .greater_than(st2[0])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] get_st(input int sel);
        case (sel)
            0:       return st0;
            1:       return st1;
            default: return st2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start; returns sampled in cycle T+1
    task automatic start_op(input int sel, input logic [15:0] a, input logic [15:0] b);
        case (sel)
            0:       begin s0 = 1'b1; a0 = a[3:0]; b0 = b[3:0]; end
            1:       begin s1 = 1'b1; a1 = a[3:0]; b1 = b[3:0]; end
            default: begin s2 = 1'b1; a2 = a;      b2 = b;      end
        endcase
        tick();
        case (sel)
            0:       s0 = 1'b0;
            1:       s1 = 1'b0;
            default: s2 = 1'b0;
        endcase
    endtask

    // Bounded wait for done; lat is the cycle number relative to the accept edge
    task automatic wait_done(input int sel, input int lat0, output int l, output int nb);
        logic [4:0] s;
        l  = lat0;
        nb = 0;
        s  = get_st(sel);
        while (!s[3] && l < 20) begin
            if (s[4]) nb++;
            tick();
            l++;
            s = get_st(sel);
        end
    endtask

    initial begin
        reset = 1'b1;
        s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        tick();
        tick();
        check("reset_outputs", 32'(st0), 32'h0);
        reset = 1'b0;
        tick();

        // 1: 0xA < 0xB, full latency
        start_op(0, 16'hA, 16'hB);
        wait_done(0, 1, lat, nbusy);
        check("t1_result", 32'(st0[2:0]), 32'b100);
        check("t1_latency", 32'(lat), 32'd5);
        check("t1_busy_cycles", 32'(nbusy), 32'd4);
        tick();
        check("t1_done_pulse", 32'(st0[4:3]), 32'b00);
        check("t1_result_hold", 32'(st0[2:0]), 32'b100);

        // 2: 0x8 > 0x7 (MS digit differs), then equal operands
        start_op(0, 16'h8, 16'h7);
        wait_done(0, 1, lat, nbusy);
        check("t2_gt_result", 32'(st0[2:0]), 32'b001);
        check("t2_gt_latency", 32'(lat), (EARLY != 0) ? 32'd2 : 32'd5);
        check("t2_gt_busy", 32'(nbusy), (EARLY != 0) ? 32'd1 : 32'd4);
        tick();
        start_op(0, 16'h5, 16'h5);
        wait_done(0, 1, lat, nbusy);
        check("t2_eq_result", 32'(st0[2:0]), 32'b010);
        check("t2_eq_latency", 32'(lat), 32'd5);
        tick();

        // 3: signed ordering
        start_op(1, 16'h8, 16'h7);
        wait_done(1, 1, lat, nbusy);
        check("t3_neg8_lt_pos7", 32'(st1[2:0]), 32'b100);
        check("t3_neg8_latency", 32'(lat), (EARLY != 0) ? 32'd2 : 32'd5);
        tick();
        start_op(1, 16'hF, 16'hE);
        wait_done(1, 1, lat, nbusy);
        check("t3_neg1_gt_neg2", 32'(st1[2:0]), 32'b001);
        check("t3_neg1_latency", 32'(lat), 32'd5);
        tick();

        // 4: 16-bit, 4-bit digits, equal; start stays high with new operands
        start_op(2, 16'h1234, 16'h1234);
        s2 = 1'b1; a2 = 16'h1235; b2 = 16'h1234;
        wait_done(2, 1, lat, nbusy);
        check("t4_eq_result", 32'(st2[2:0]), 32'b010);
        check("t4_eq_latency", 32'(lat), 32'd5);
        tick();
        s2 = 1'b0;
        check("t4_b2b_busy", 32'(st2[4:0]), 32'b10000);
        wait_done(2, 1, lat, nbusy);
        check("t4_b2b_result", 32'(st2[2:0]), 32'b001);
        check("t4_b2b_latency", 32'(lat), 32'd5);
        tick();

        // 5a: start pulsed while busy is ignored
        start_op(0, 16'h3, 16'h9);
        s0 = 1'b1; a0 = 4'hF; b0 = 4'h0;
        tick();
        s0 = 1'b0;
        wait_done(0, 2, lat, nbusy);
        check("t5_ignore_result", 32'(st0[2:0]), 32'b100);
        check("t5_ignore_latency", 32'(lat), (EARLY != 0) ? 32'd2 : 32'd5);
        tick();
        check("t5_no_extra_op", 32'(st0[4:3]), 32'b00);

        // 5b: asynchronous reset mid-SHIFT
        start_op(0, 16'h6, 16'h6);
        tick();
        check("t5_busy_before_reset", 32'(st0[4]), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_reset", 32'(st0), 32'h0);
        tick();
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (st0[3]) ndone++;
            tick();
        end
        check("t5_no_done_after_reset", 32'(ndone), 32'd0);
        check("t5_idle_after_reset", 32'(st0), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_magnitude_comparator

`default_nettype wire
